// File: rtl/vec_pkg.sv
// Shared constants, typedefs and sequencer state encoding for the vector memory path.
package vec_pkg;
  localparam int unsigned LANES = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = $clog2(LANES);

  typedef logic [LW-1:0] lane_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] elem_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} seq_state_t;
endpackage

// File: rtl/vec_rd_capture.sv
// Read-return pipeline: tracks lane index/valid for RD_LAT cycles and lands
// returned memory data into the matching lane of the load vector.
module vec_rd_capture
  import vec_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv_i,
  input  logic                      vld_i,
  input  lane_t                     lane_i,
  input  elem_t                     rdata_i,
  output logic [LANES-1:0][DW-1:0]  ld_vec_o
);

  logic  [RD_LAT-1:0] vld_q;
  lane_t [RD_LAT-1:0] lane_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      lane_q   <= '0;
      ld_vec_o <= '0;
    end else if (adv_i) begin
      vld_q[0]  <= vld_i;
      lane_q[0] <= lane_i;
      for (int k = 1; k < int'(RD_LAT); k++) begin
        vld_q[k]  <= vld_q[k-1];
        lane_q[k] <= lane_q[k-1];
      end
      // Tail stage lines up with the data returned for that lane's address
      if (vld_q[RD_LAT-1]) begin
        ld_vec_o[lane_q[RD_LAT-1]] <= rdata_i;
      end
    end
  end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: walks 16 snapshotted lane addresses through a
// single-port data memory, one lane per cycle, then signals done.
module vec_mem_seq
  import vec_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [LANES-1:0][AW-1:0]  addr_vec,
  input  logic [LANES-1:0][DW-1:0]  st_vec,
  output logic [AW-1:0]             mem_addr,
  output logic                      mem_we,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata,
  output logic [LANES-1:0][DW-1:0]  ld_vec,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DLW = 2;

  seq_state_t               state_q;
  lane_t                    lane_q;
  logic [DLW-1:0]           drain_q;
  logic                     store_q;
  logic [LANES-1:0][AW-1:0] addr_snap_q;
  logic [LANES-1:0][DW-1:0] st_snap_q;
  addr_t                    mem_addr_q;
  logic                     mem_we_q;
  elem_t                    mem_wdata_q;
  logic                     busy_q;
  logic                     done_q;

  lane_t lane_nxt_c;
  logic  cap_adv_c;
  logic  cap_vld_c;

  assign lane_nxt_c = lane_q + lane_t'(1);
  assign cap_adv_c  = (state_q == ISSUE) || (state_q == DRAIN);
  assign cap_vld_c  = (state_q == ISSUE) && !store_q;

  // Sequencer FSM; memory drive for lane i is registered so it appears in the i-th ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      drain_q     <= '0;
      store_q     <= 1'b0;
      addr_snap_q <= '0;
      st_snap_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_snap_q <= addr_vec;
            st_snap_q   <= st_vec;
            store_q     <= is_store;
            lane_q      <= '0;
            busy_q      <= 1'b1;
            mem_addr_q  <= addr_vec[0];
            mem_we_q    <= is_store;
            mem_wdata_q <= is_store ? st_vec[0] : '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lane_q == lane_t'(LANES - 1)) begin
            drain_q <= '0;
            if (store_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            lane_q      <= lane_nxt_c;
            mem_addr_q  <= addr_snap_q[lane_nxt_c];
            mem_we_q    <= store_q;
            mem_wdata_q <= store_q ? st_snap_q[lane_nxt_c] : '0;
          end
        end
        DRAIN: begin
          if (drain_q == DLW'(RD_LAT - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            drain_q <= drain_q + DLW'(1);
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  vec_rd_capture #(
    .RD_LAT (RD_LAT)
  ) u_cap (
    .clk      (clk),
    .rst      (rst),
    .adv_i    (cap_adv_c),
    .vld_i    (cap_vld_c),
    .lane_i   (lane_q),
    .rdata_i  (mem_rdata),
    .ld_vec_o (ld_vec)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with read latency 1 and 3 instances side by side.
module tb_vec_mem_seq;
  import vec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     start1, start3, is_store;
  logic [LANES-1:0][AW-1:0] addr_vec;
  logic [LANES-1:0][DW-1:0] st_vec;

  logic [AW-1:0]            mem_addr1, mem_addr3;
  logic                     we1, we3, busy1, busy3, done1, done3;
  logic [DW-1:0]            wd1, wd3, rd1, rd3;
  logic [LANES-1:0][DW-1:0] ld1, ld3;

  vec_mem_seq #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .is_store(is_store),
    .addr_vec(addr_vec), .st_vec(st_vec),
    .mem_addr(mem_addr1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd1),
    .ld_vec(ld1), .busy(busy1), .done(done1)
  );

  vec_mem_seq #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .is_store(is_store),
    .addr_vec(addr_vec), .st_vec(st_vec),
    .mem_addr(mem_addr3), .mem_we(we3), .mem_wdata(wd3), .mem_rdata(rd3),
    .ld_vec(ld3), .busy(busy3), .done(done3)
  );

  // Memory model: read data is the low byte of the address, RD_LAT cycles later
  logic [7:0]       rp1;
  logic [2:0][7:0]  rp3;
  always @(posedge clk) begin
    rp1    <= mem_addr1[7:0];
    rp3[0] <= mem_addr3[7:0];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rd1 = rp1;
  assign rd3 = rp3[2];

  // Observation mux for the instance under test
  logic                     sel;
  logic [AW-1:0]            o_addr;
  logic                     o_we, o_busy, o_done;
  logic [DW-1:0]            o_wd;
  logic [LANES-1:0][DW-1:0] o_ld;
  always_comb begin
    o_addr = sel ? mem_addr3 : mem_addr1;
    o_we   = sel ? we3   : we1;
    o_wd   = sel ? wd3   : wd1;
    o_busy = sel ? busy3 : busy1;
    o_done = sel ? done3 : done1;
    o_ld   = sel ? ld3   : ld1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic s3, input logic v);
    if (s3) start3 = v;
    else    start1 = v;
  endtask

  typedef struct {
    bit         sel3;
    bit         st;
    logic [15:0] base;
    logic [7:0]  dbase;
    bit         disturb;
    int         exp_done;
    int         exp_wr;
    int         exp_busy;
  } vec_t;

  vec_t tbl [7];
  logic [LANES-1:0][DW-1:0] exp_ld1 = '0;
  logic [LANES-1:0][DW-1:0] exp_ld3 = '0;

  task automatic run_vec(input int idx, input vec_t v);
    int done_at = 0, ndone = 0, nwr = 0, aerr = 0, derr = 0, nbusy = 0;
    logic [LANES-1:0][DW-1:0] ld_at_done = '0;
    logic [LANES-1:0][DW-1:0] exp_ld;
    sel = v.sel3;
    exp_ld = v.sel3 ? exp_ld3 : exp_ld1;
    if (!v.st) begin
      for (int i = 0; i < int'(LANES); i++) exp_ld[i] = 8'(v.base + 16'(i));
    end
    for (int i = 0; i < int'(LANES); i++) begin
      addr_vec[i] = v.base + 16'(i);
      st_vec[i]   = v.dbase + 8'(i);
    end
    is_store = v.st;
    set_start(v.sel3, 1'b1);
    tick();
    set_start(v.sel3, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      if (o_done) begin ndone++; done_at = k; ld_at_done = o_ld; end
      if (o_busy) nbusy++;
      if (o_we) nwr++;
      if (k <= 16) begin
        if (o_addr !== v.base + 16'(k - 1)) aerr++;
        if (v.st && o_wd !== v.dbase + 8'(k - 1)) derr++;
        if (!v.st && o_wd !== 8'h00) derr++;
      end else if (o_addr !== v.base + 16'(15)) begin
        aerr++;
      end
      if (v.disturb && k == 3) begin
        addr_vec = ~addr_vec;
        st_vec   = ~st_vec;
      end
      set_start(v.sel3, v.disturb && (k == 5 || k == 17));
      tick();
    end
    set_start(v.sel3, 1'b0);
    check($sformatf("v%0d_done_cycle", idx), 128'(done_at), 128'(v.exp_done));
    check($sformatf("v%0d_done_count", idx), 128'(ndone), 128'(1));
    check($sformatf("v%0d_writes", idx), 128'(nwr), 128'(v.exp_wr));
    check($sformatf("v%0d_addr_errs", idx), 128'(aerr), 128'(0));
    check($sformatf("v%0d_wdata_errs", idx), 128'(derr), 128'(0));
    check($sformatf("v%0d_busy_cycles", idx), 128'(nbusy), 128'(v.exp_busy));
    check($sformatf("v%0d_ld_vec", idx), 128'(ld_at_done), 128'(exp_ld));
    if (v.sel3) exp_ld3 = exp_ld;
    else        exp_ld1 = exp_ld;
  endtask

  initial begin
    int ndone_rst;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; is_store = 1'b0; sel = 1'b0;
    addr_vec = '0; st_vec = '0;
    tbl[0] = '{1'b0, 1'b1, 16'h0100, 8'hA0, 1'b0, 17, 16, 16};
    tbl[1] = '{1'b0, 1'b0, 16'h0020, 8'h00, 1'b0, 18,  0, 17};
    tbl[2] = '{1'b0, 1'b0, 16'hFFF8, 8'h00, 1'b0, 18,  0, 17};
    tbl[3] = '{1'b0, 1'b1, 16'h0200, 8'h30, 1'b1, 17, 16, 16};
    tbl[4] = '{1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 20,  0, 19};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFC, 8'h10, 1'b0, 17, 16, 16};
    tbl[6] = '{1'b1, 1'b0, 16'hFFF8, 8'h00, 1'b1, 20,  0, 19};
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_mem_addr", 128'({mem_addr1, mem_addr3}), 128'(0));
    check("rst_we_busy_done", 128'({we1, we3, busy1, busy3, done1, done3}), 128'(0));
    check("rst_wdata", 128'({wd1, wd3}), 128'(0));
    check("rst_ld1", 128'(ld1), 128'(0));
    check("rst_ld3", 128'(ld3), 128'(0));

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Start held across FIN and the following IDLE cycle: only the IDLE one is taken
    sel = 1'b0;
    is_store = 1'b1;
    for (int i = 0; i < int'(LANES); i++) begin
      addr_vec[i] = 16'h0300 + 16'(i);
      st_vec[i]   = 8'h50 + 8'(i);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (16) tick();
    check("b2b_fin_done", 128'(done1), 128'(1));
    start1 = 1'b1;
    tick();
    check("b2b_idle_busy", 128'({busy1, done1}), 128'(0));
    tick();
    start1 = 1'b0;
    check("b2b_accept", 128'({busy1, we1, mem_addr1, wd1}), 128'({1'b1, 1'b1, 16'h0300, 8'h50}));
    for (int c = 0; c < 20 && !done1; c++) tick();
    check("b2b_second_done", 128'(done1), 128'(1));
    tick();

    // Reset in the middle of a load aborts and clears the partial result
    is_store = 1'b0;
    for (int i = 0; i < int'(LANES); i++) addr_vec[i] = 16'h0030 + 16'(i);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy_we", 128'({busy1, we1, done1}), 128'(0));
    check("rst_mid_addr", 128'(mem_addr1), 128'(0));
    check("rst_mid_ld1", 128'(ld1), 128'(0));
    check("rst_mid_ld3", 128'(ld3), 128'(0));
    ndone_rst = 0;
    for (int k = 0; k < 24; k++) begin
      if (done1) ndone_rst++;
      if (we1) ndone_rst++;
      tick();
    end
    check("rst_mid_no_done_or_write", 128'(ndone_rst), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
